// File: rtl/fir_frame_collector_pkg.sv
// fir_frame_collector_pkg: frame geometry shared by the FIR, collector and FFT stages
package fir_frame_collector_pkg;
    localparam int DW     = 16;
    localparam int N      = 16;
    localparam int FRAMES = 64;
    localparam int CNT_W  = $clog2(N);
    localparam int IDX_W  = $clog2(FRAMES);
endpackage

// File: rtl/fir_frame_collector_bank.sv
// frame_bank: one N x DW sample register bank, indexed write, flattened read
module frame_bank
    import fir_frame_collector_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [CNT_W-1:0]  idx_i,
    input  logic [DW-1:0]     d_i,
    output logic [N*DW-1:0]   q_o
);
    logic [N*DW-1:0] mem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '0;
        else if (we_i) mem_q[idx_i*DW +: DW] <= d_i;
    end

    assign q_o = mem_q;
endmodule

// File: rtl/fir_frame_collector.sv
// fir_frame_collector: ping-pong collection of FIR samples into N-sample frames for the FFT
module fir_frame_collector
    import fir_frame_collector_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fir_valid,
    input  logic [DW-1:0]     fir_d,
    input  logic              frame_ready,
    output logic              frame_valid,
    output logic [N*DW-1:0]   frame_data,
    output logic [IDX_W-1:0]  frame_idx,
    output logic              overflow,
    output logic              done
);
    logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]       full_q, full_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d, done_q, done_d;
    logic             accept, xfer, last, at_end;
    logic [N*DW-1:0]  q0, q1;

    always_comb begin
        accept    = fir_valid && !done_q && !full_q[wr_bank_q];
        xfer      = full_q[rd_bank_q] && frame_ready;
        last      = wr_cnt_q == CNT_W'(N-1);
        at_end    = idx_q == IDX_W'(FRAMES-1);
        wr_cnt_d  = accept ? (last ? '0 : wr_cnt_q + 1'b1) : wr_cnt_q;
        wr_bank_d = wr_bank_q ^ (accept && last);
        rd_bank_d = rd_bank_q ^ xfer;
        idx_d     = (xfer && !at_end) ? idx_q + 1'b1 : idx_q;
        done_d    = done_q | (xfer && at_end);
        ovf_d     = ovf_q | (fir_valid && !done_q && full_q[wr_bank_q]);
        // the writing bank is never full, so release and completion touch different bits
        full_d = full_q;
        if (xfer) full_d[rd_bank_q] = 1'b0;
        if (accept && last) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            full_q    <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            full_q    <= full_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    frame_bank u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we_i  (accept && !wr_bank_q),
        .idx_i (wr_cnt_q),
        .d_i   (fir_d),
        .q_o   (q0)
    );

    frame_bank u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we_i  (accept && wr_bank_q),
        .idx_i (wr_cnt_q),
        .d_i   (fir_d),
        .q_o   (q1)
    );

    assign frame_valid = full_q[rd_bank_q];
    assign frame_data  = rd_bank_q ? q1 : q0;
    assign frame_idx   = idx_q;
    assign overflow    = ovf_q;
    assign done        = done_q;
endmodule

// File: tb/tb_fir_frame_collector.sv
// tb_fir_frame_collector: directed and random stimulus against a queue-based frame model
module tb_fir_frame_collector;
    import fir_frame_collector_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fir_valid = 1'b0;
    logic [DW-1:0]     fir_d = '0;
    logic              frame_ready = 1'b0;
    logic              frame_valid;
    logic [N*DW-1:0]   frame_data;
    logic [IDX_W-1:0]  frame_idx;
    logic              overflow;
    logic              done;

    int compared = 0;
    int mismatched = 0;

    logic [DW-1:0]   cur[$];
    logic [N*DW-1:0] pend[$];
    int              nx;
    logic            ovf_m, done_m;

    fir_frame_collector dut (
        .clk         (clk),
        .rst         (rst),
        .fir_valid   (fir_valid),
        .fir_d       (fir_d),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_idx   (frame_idx),
        .overflow    (overflow),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [N*DW-1:0] pack_cur();
        logic [N*DW-1:0] r = '0;
        foreach (cur[i]) r[i*DW +: DW] = cur[i];
        return r;
    endfunction

    task automatic model_clear();
        cur.delete();
        pend.delete();
        nx = 0;
        ovf_m = 1'b0;
        done_m = 1'b0;
    endtask

    task automatic check(input string tag);
        logic             ev;
        logic [IDX_W-1:0] ei;
        ev = pend.size() != 0;
        ei = IDX_W'(nx >= FRAMES ? FRAMES - 1 : nx);
        compared++;
        assert (frame_valid === ev) else begin
            mismatched++;
            $error("FAIL %s frame_valid got %0b exp %0b", tag, frame_valid, ev);
        end
        compared++;
        assert (frame_idx === ei) else begin
            mismatched++;
            $error("FAIL %s frame_idx got %0d exp %0d", tag, frame_idx, ei);
        end
        compared++;
        assert (overflow === ovf_m) else begin
            mismatched++;
            $error("FAIL %s overflow got %0b exp %0b", tag, overflow, ovf_m);
        end
        compared++;
        assert (done === done_m) else begin
            mismatched++;
            $error("FAIL %s done got %0b exp %0b", tag, done, done_m);
        end
        if (ev) begin
            compared++;
            assert (frame_data === pend[0]) else begin
                mismatched++;
                $error("FAIL %s frame_data got %h exp %h", tag, frame_data, pend[0]);
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input string tag);
        logic xf, acc;
        fir_valid = v;
        fir_d = d;
        frame_ready = r;
        @(posedge clk);
        xf  = pend.size() != 0 && r;
        acc = v && !done_m && pend.size() < 2;
        if (v && !done_m && pend.size() >= 2) ovf_m = 1'b1;
        if (xf) begin
            void'(pend.pop_front());
            nx++;
            if (nx == FRAMES) done_m = 1'b1;
        end
        if (acc) begin
            cur.push_back(d);
            if (cur.size() == N) begin
                pend.push_back(pack_cur());
                cur.delete();
            end
        end
        #1;
        check(tag);
    endtask

    task automatic do_reset(input string tag);
        fir_valid = 1'b0;
        frame_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_clear();
        check(tag);
        compared++;
        assert (frame_data === '0) else begin
            mismatched++;
            $error("FAIL %s frame_data got %h exp 0", tag, frame_data);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] first;
        model_clear();
        #1;
        do_reset("reset");

        // first frame streamed with ready high
        for (int k = 1; k <= N; k++) cyc(1'b1, DW'(k), 1'b1, "stream1");
        compared++;
        assert (frame_data[DW-1:0] === 16'h0001 && frame_data[N*DW-1 -: DW] === 16'h0010) else begin
            mismatched++;
            $error("FAIL first_frame lo %h hi %h exp 0001 0010", frame_data[DW-1:0], frame_data[N*DW-1 -: DW]);
        end
        cyc(1'b0, '0, 1'b1, "xfer1");

        // fill both banks with ready low, then overflow
        for (int k = 0; k < 2*N; k++) cyc(1'b1, DW'($urandom), 1'b0, "fill2");
        cyc(1'b1, DW'($urandom), 1'b0, "drop");
        compared++;
        assert (overflow === 1'b1) else begin
            mismatched++;
            $error("FAIL overflow_set got %0b exp 1", overflow);
        end
        repeat (3) cyc(1'b0, '0, 1'b0, "hold");
        repeat (2) cyc(1'b0, '0, 1'b1, "drain");
        repeat (3) cyc(1'b0, '0, 1'b1, "ready_idle");

        // reset mid-frame discards partial data
        do_reset("reset2");
        for (int k = 0; k < 9; k++) cyc(1'b1, DW'($urandom), 1'b0, "partial");
        do_reset("reset_mid");
        first = DW'($urandom);
        cyc(1'b1, first, 1'b0, "post_reset");
        for (int k = 1; k < N; k++) cyc(1'b1, DW'($urandom), 1'b0, "post_reset");
        compared++;
        assert (frame_idx === '0 && frame_data[DW-1:0] === first) else begin
            mismatched++;
            $error("FAIL post_reset_frame idx %0d s0 %h exp 0 %h", frame_idx, frame_data[DW-1:0], first);
        end
        cyc(1'b0, '0, 1'b1, "post_reset_xfer");

        // bank completion coinciding with transfer of the other bank
        do_reset("reset3");
        for (int k = 0; k < 2*N - 1; k++) cyc(1'b1, DW'($urandom), 1'b0, "coinc_fill");
        cyc(1'b1, DW'($urandom), 1'b1, "coinc");
        compared++;
        assert (frame_valid === 1'b1 && frame_idx === IDX_W'(1)) else begin
            mismatched++;
            $error("FAIL coinc valid %0b idx %0d exp 1 1", frame_valid, frame_idx);
        end
        cyc(1'b0, '0, 1'b1, "coinc_next");

        // random traffic
        for (int k = 0; k < 400; k++)
            cyc($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 1) == 1, "random");

        // complete run of FRAMES frames
        do_reset("reset4");
        for (int k = 0; k < N*FRAMES; k++) cyc(1'b1, DW'($urandom), 1'b1, "run");
        repeat (2) cyc(1'b0, '0, 1'b1, "run_tail");
        compared++;
        assert (done === 1'b1 && frame_idx === IDX_W'(FRAMES-1) && overflow === 1'b0) else begin
            mismatched++;
            $error("FAIL run_end done %0b idx %0d ovf %0b exp 1 %0d 0", done, frame_idx, overflow, FRAMES-1);
        end
        repeat (N + 2) cyc(1'b1, DW'($urandom), 1'b1, "after_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
